// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks: FSM state encoding and default width.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor: diff = x - y, borrow set when y > x.
// Latency: combinational.
// Backpressure: n/a.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y;
  assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one bit per clock; SERIAL_SUB_OVF_EN adds OVF.
// Latency: accept edge + WIDTH shift cycles, then result held in DONE (WIDTH+2 cycles per op).
// Backpressure: result held until out_ready; in_ready only in IDLE, never same cycle as retire.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [CNT_W-1:0] cnt;
  logic             borrow_q, bout_q;
  logic             a0, b0;
  logic             hs_diff, hs_borrow, diff_bit, bin_borrow, borrow_nxt;
  logic             last_bit;

  assign a0 = a_sr[0];
  assign b0 = b_sr[0];

  // Full-subtractor cell: (a0 - b0) then minus the incoming borrow.
  half_subtractor u_hs_ab (
    .x      (a0),
    .y      (b0),
    .diff   (hs_diff),
    .borrow (hs_borrow)
  );

  half_subtractor u_hs_bin (
    .x      (hs_diff),
    .y      (borrow_q),
    .diff   (diff_bit),
    .borrow (bin_borrow)
  );

  assign borrow_nxt = hs_borrow | bin_borrow;
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The result reg doubles as the D output; it shifts only while in SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= A;
            b_sr     <= B;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          d_sr     <= {diff_bit, d_sr[WIDTH-1:1]};
          borrow_q <= borrow_nxt;
          cnt      <= last_bit ? '0 : cnt + CNT_W'(1);
          if (last_bit) bout_q <= borrow_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last bit a0/b0 are the operand sign bits and diff_bit is the result sign bit.
  always_ff @(posedge clk) begin
    if (!rst_n)                         ovf_q <= 1'b0;
    else if (state == SHIFT && last_bit) ovf_q <= (a0 ^ b0) & (a0 ^ diff_bit);
  end

  assign OVF = ovf_q;
`endif

  assign D    = d_sr;
  assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed cases, backpressure, mid-op reset, random.
// Define SERIAL_SUB_OVF_EN to also check OVF.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         in_ready, out_valid, BOUT;
  logic [W-1:0] D;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 1'b0;
  int   lat;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .BOUT      (BOUT)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d    = a - b;
    e.bout = (a < b);
    e.ovf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.d[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the block is ready, then lets the accept edge pass.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    else           sb.push_back(model(a, b));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      step();
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // A result retires on the next rising edge when out_valid && out_ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("D", 32'(D), 32'(mon_e.d));
        chk("BOUT", 32'(BOUT), 32'(mon_e.bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("OVF", 32'(OVF), 32'(mon_e.ovf));
`endif
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_BOUT", 32'(BOUT), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Cycle 0 presents the operands; out_valid must first appear in cycle 9.
    send(8'h05, 8'h03);
    lat = 1;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd9);
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    step();
    chk("in_ready_after_retire", 32'(in_ready), 32'd1);
    chk("out_valid_after_retire", 32'(out_valid), 32'd0);

    send(8'h03, 8'h05);
    send(8'h00, 8'h00);
    send(8'hFF, 8'h01);
    drain();

    // Backpressure: result must hold while operand inputs churn.
    out_ready = 1'b0;
    send(8'h10, 8'h01);
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      A        = W'($urandom);
      B        = W'($urandom);
      in_valid = i[0];
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_D", 32'(D), 32'h0F);
      chk("bp_hold_BOUT", 32'(BOUT), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) step();
    chk("bp_no_ghost", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    // Reset during SHIFT cycle 4 discards the operation.
    send(8'hAA, 8'h55);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_D", 32'(D), 32'd0);
    send(8'h01, 8'h01);
    drain();

`ifdef SERIAL_SUB_OVF_EN
    send(8'h80, 8'h01);
    send(8'h05, 8'h03);
    drain();
`endif

    fork
      begin
        repeat (1000) begin
          send(W'($urandom), W'($urandom));
          repeat ($urandom_range(0, 2)) step();
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
